spi_sensor_emu: RTL
===================

// Module: spi_sensor_emu
// PURPOSE
//  Synthesizable multi-channel RHS2116-style SPI slave emulator; replaces behavioural sensor models in system benches and FPGA loopback builds.
//  Faces the SPI master port of the coax encoder (cs_n/sclk/mosi/miso). Oversamples the SPI pins in clk_spi and serves one FRAME_W-bit word per cs_n frame.
//  Payload source is run-time selectable: counter, channel-tagged, PRBS or MOSI echo. Captured MOSI words and framing errors are reported.
// PARAMETERS
//  FRAME_W    32          bits per SPI frame; legal range 16..32
//  NUM_CH     16          channels cycled in tagged mode; power of 2, 2..16
//  CPHA       1           1: miso updates on sclk rise, master samples on fall; 0: MSB valid at cs_n fall, updates on sclk fall
//  PRBS_SEED  32'h1       PRBS31 reset seed; must be non-zero
// PORTS
//  clk_spi      in   1        emulator clock; sclk half-period >= 4 clk_spi cycles
//  rst_n        in   1        asynchronous reset, active-low
//  enable       in   1        1: respond to frames; sampled at frame start
//  mode         in   2        payload mode; sampled at frame start
//  cs_n         in   1        SPI chip select, asynchronous pin
//  sclk         in   1        SPI clock (CPOL=0), asynchronous pin
//  mosi         in   1        SPI data from master, asynchronous pin
//  miso         out  1        SPI data to master, MSB first
//  cmd_data     out  FRAME_W  last complete MOSI word
//  cmd_valid    out  1        1-cycle pulse when cmd_data updates
//  frame_cnt    out  16       completed frames, wraps at 16'hFFFF -> 0
//  short_frame  out  1        1-cycle pulse: cs_n rose after 1..FRAME_W-1 bits
// BEHAVIOUR
//  Reset: miso=0, cmd_data=0, cmd_valid=0, frame_cnt=0, short_frame=0, payload counter=0, channel=0, PRBS=PRBS_SEED.
//  Reset: cs_n/sclk sync regs = 1/0/0; armed=0.
//  Sync: 2-FF synchronizer per pin, then edge detect. A pad edge affects miso or state 3 clk_spi cycles later.
//  Arming: frame start = synced cs_n falling edge while armed. armed sets once synced cs_n is seen high after reset.
//  Arming consequence: cs_n low at reset release is ignored until cs_n has been high.
//  States: IDLE -> SHIFT on frame start with enable=1. With enable=0, remain IDLE and drive miso=0 for the whole frame.
//  States: SHIFT -> IDLE on cs_n rise. Reset mid-frame returns to IDLE and forces miso=0.
//  Payload latched into shift reg at frame start from mode:
//    0 COUNT:  free counter, FRAME_W wide
//    1 TAGGED: {channel[3:0], counter[FRAME_W-5:0]}
//    2 PRBS:   PRBS31 (x^31+x^28+1) state; low FRAME_W bits, zero-extended if FRAME_W=32
//    3 ECHO:   current cmd_data
//  Shift: CPHA=1 loads MSB onto miso at the 1st sclk rise and shifts on each later rise. CPHA=0 drives MSB at frame start and shifts on each sclk fall.
//  Shift: mosi is sampled on the opposite edge; bit_cnt counts sampling edges.
//  bit_cnt saturates at FRAME_W. Edges beyond FRAME_W drive miso=0 and are ignored; the frame still completes normally.
//  cs_n rise, bit_cnt==FRAME_W: cmd_data<=mosi shift reg, cmd_valid pulse, frame_cnt+1, counter+1, channel+1 mod NUM_CH, PRBS advances FRAME_W steps.
//  cs_n rise, 0<bit_cnt<FRAME_W: short_frame pulse only; no counter, channel, PRBS or cmd update.
//  cs_n rise, bit_cnt==0: silent abort, no pulses.
//  Outside SHIFT: miso=0. Counter, channel and frame_cnt wrap silently.
//  Frame-end updates and the next frame start never coincide (cs_n high >= 1 sync cycle), so there is no simultaneous-event priority.
// STRUCTURE
//  Shared header spi_coax_defs.vh: MODE_COUNT/MODE_TAGGED/MODE_PRBS/MODE_ECHO localparams and PRBS31 tap constants.
//  Sub-module spi_edge_sync (2-FF sync + rise/fall pulses; reset-value parameter), instantiated for cs_n and sclk. mosi uses a plain 2-FF.
//  Remainder is one FSM plus datapath, ~200 lines.
// TESTING
//  1 mode=0, CPHA=1, 3 frames of 32 clocks -> master reads 00000000, 00000001, 00000002; frame_cnt=3.
//  2 mode=1, NUM_CH=4, 5 frames -> top nibble 0,1,2,3,0; low 28 bits 0..4.
//  3 mode=3, frame 1 MOSI=A5A5_1234 -> cmd_valid once, cmd_data=A5A51234; frame 2 miso reads A5A51234.
//  4 cs_n rises after 17 bits -> short_frame pulse, frame_cnt unchanged; next full frame returns counter value unchanged.
//  5 rst_n pulsed at bit 10 of a frame, cs_n still low -> miso=0; no response until cs_n high then low; next frame reads 00000000.
//  6 mode=2 vs reference PRBS31 model over 64 frames -> exact match; 40-clock frame -> bits 33..40 read 0, frame_cnt+1.

Source files
------------

// File: rtl/spi_sensor_emu_pkg.sv
// Shared definitions for the SPI sensor emulator: payload modes, PRBS31 taps and FSM state type.
package spi_sensor_emu_pkg;

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_TAGGED = 2'd1;
  localparam logic [1:0] MODE_PRBS   = 2'd2;
  localparam logic [1:0] MODE_ECHO   = 2'd3;

  // x^31 + x^28 + 1, Fibonacci form: feedback from state bits 30 and 27
  localparam int unsigned PRBS_TAP_A = 30;
  localparam int unsigned PRBS_TAP_B = 27;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  function automatic logic [30:0] prbs_step(input logic [30:0] s);
    return {s[29:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

  function automatic logic [30:0] prbs_advance(input logic [30:0] s, input int unsigned steps);
    logic [30:0] r;
    r = s;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < steps) r = prbs_step(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sensor_emu_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin plus one history flop for rise/fall pulses.
module spi_sensor_emu_edge_sync #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_spi,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RstVal}};
    end else begin
      sync_q <= {sync_q[1:0], pin};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_sensor_emu.sv
// RHS2116-style SPI slave emulator: oversampled pins, one FRAME_W-bit word per cs_n frame,
// selectable payload source, MOSI capture and framing-error reporting.
module spi_sensor_emu
  import spi_sensor_emu_pkg::*;
#(
  parameter int unsigned FRAME_W   = 32,
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned CPHA      = 1,
  parameter logic [31:0] PRBS_SEED = 32'h1
) (
  input  logic               clk_spi,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               cs_n,
  input  logic               sclk,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] cmd_data,
  output logic               cmd_valid,
  output logic [15:0]        frame_cnt,
  output logic               short_frame
);

  localparam int unsigned CntW = $clog2(FRAME_W + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FRAME_W);
  localparam logic [3:0] ChMask = 4'(NUM_CH - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic [1:0] mosi_q;

  spi_sensor_emu_edge_sync #(.RstVal(1'b1)) u_cs_sync (
    .clk_spi (clk_spi),
    .rst_n   (rst_n),
    .pin     (cs_n),
    .level   (cs_lvl),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  spi_sensor_emu_edge_sync #(.RstVal(1'b0)) u_sclk_sync (
    .clk_spi (clk_spi),
    .rst_n   (rst_n),
    .pin     (sclk),
    .level   (sclk_lvl),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= 2'b00;
    end else begin
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // Arming waits until the synchronizer holds real pad samples, so a cs_n held low
  // through reset release cannot masquerade as a frame start.
  logic [1:0] settle_q;
  logic       armed_q;

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && cs_lvl && !sclk_lvl) armed_q <= 1'b1;
    end
  end

  logic frame_start, drive_edge, sample_edge;
  assign frame_start = armed_q & cs_fall;
  assign drive_edge  = (CPHA != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? sclk_fall : sclk_rise;

  state_e state_q, state_d;

  logic [CntW-1:0]    bit_cnt_q;
  logic [FRAME_W-1:0] tx_q, rx_q, cmd_data_q, counter_q;
  logic [3:0]         channel_q;
  logic [30:0]        prbs_q;
  logic [15:0]        frame_cnt_q;
  logic               miso_q, cmd_valid_q, short_frame_q;

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (frame_start && enable) state_d = StShift;
      StShift: if (cs_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic do_load, do_drive, do_sample, end_full, end_short;

  always_comb begin
    do_load   = 1'b0;
    do_drive  = 1'b0;
    do_sample = 1'b0;
    end_full  = 1'b0;
    end_short = 1'b0;
    unique case (state_q)
      StIdle: do_load = frame_start & enable;
      StShift: begin
        if (cs_rise) begin
          end_full  = (bit_cnt_q == FullCnt);
          end_short = (bit_cnt_q != '0) && (bit_cnt_q != FullCnt);
        end else begin
          do_drive  = drive_edge;
          do_sample = sample_edge && (bit_cnt_q < FullCnt);
        end
      end
      default: ;
    endcase
  end

  logic [31:0]        prbs_ext;
  logic [FRAME_W-1:0] payload;

  assign prbs_ext = {1'b0, prbs_q};

  always_comb begin
    payload = '0;
    unique case (mode)
      MODE_COUNT:  payload = counter_q;
      MODE_TAGGED: payload = {channel_q, counter_q[FRAME_W-5:0]};
      MODE_PRBS:   payload = prbs_ext[FRAME_W-1:0];
      MODE_ECHO:   payload = cmd_data_q;
      default:     payload = '0;
    endcase
  end

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      miso_q        <= 1'b0;
      tx_q          <= '0;
      rx_q          <= '0;
      bit_cnt_q     <= '0;
      cmd_data_q    <= '0;
      cmd_valid_q   <= 1'b0;
      short_frame_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
      counter_q     <= '0;
      channel_q     <= 4'd0;
      prbs_q        <= PRBS_SEED[30:0];
    end else begin
      cmd_valid_q   <= 1'b0;
      short_frame_q <= 1'b0;

      // CPHA=0 presents the MSB as soon as the frame starts; CPHA=1 waits for the first rise.
      if (do_load) begin
        bit_cnt_q <= '0;
        if (CPHA == 0) begin
          miso_q <= payload[FRAME_W-1];
          tx_q   <= {payload[FRAME_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
          tx_q   <= payload;
        end
      end else if (state_d != StShift) begin
        miso_q <= 1'b0;
      end else if (do_drive) begin
        miso_q <= (bit_cnt_q < FullCnt) ? tx_q[FRAME_W-1] : 1'b0;
        tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
      end

      if (do_sample) begin
        rx_q      <= {rx_q[FRAME_W-2:0], mosi_q[1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (end_full) begin
        cmd_data_q  <= rx_q;
        cmd_valid_q <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        counter_q   <= counter_q + 1'b1;
        channel_q   <= (channel_q + 4'd1) & ChMask;
        prbs_q      <= prbs_advance(prbs_q, FRAME_W);
      end

      if (end_short) short_frame_q <= 1'b1;
    end
  end

  assign miso        = miso_q;
  assign cmd_data    = cmd_data_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign short_frame = short_frame_q;

endmodule
